panda_div_cfg: RTL and testbench

Register-side controller for the `panda_div` pulse divider. It holds shadow copies of DIVISOR and FIRST_PULSE written over the block register bus, and commits them to the divider atomically on request. A commit waits for a safe point, meaning `inp_i` is low, and then issues a one-cycle FORCE_RST so the divider restarts cleanly with the new settings. It also provides a COUNT snapshot and a status register. It sits between the register bus decoder and one `panda_div` instance.

---
 rtl/panda_div_pkg.sv | 23 ++
 rtl/panda_div_safe.sv | 34 +++
 rtl/panda_div_cfg.sv | 123 ++++++++++++
 tb/tb_panda_div_cfg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_div_pkg.sv
// Shared definitions for the panda_div register-side controller:
// register addresses, commit FSM states and STATUS bit positions.
package panda_div_pkg;

  localparam logic [3:0] AddrDivisor    = 4'd0;
  localparam logic [3:0] AddrFirstPulse = 4'd1;
  localparam logic [3:0] AddrForce      = 4'd2;
  localparam logic [3:0] AddrCommit     = 4'd3;
  localparam logic [3:0] AddrCount      = 4'd4;
  localparam logic [3:0] AddrStatus     = 4'd5;

  localparam int unsigned BitBusy    = 0;
  localparam int unsigned BitErrZero = 1;
  localparam int unsigned BitErrOvr  = 2;
  localparam int unsigned BitTmo     = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StApply
  } state_e;

endpackage

// File: rtl/panda_div_safe.sv
// Safe-point detector: counts consecutive high cycles on inp_i while enabled and
// signals go on the first low input or when the count reaches TIMEOUT.
module panda_div_safe #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic inp_i,
  output logic go_o,
  output logic tmo_o
);

  localparam logic [15:0] Last = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic        last;

  assign last  = (cnt_q == Last);
  // go is only ever seen for one cycle because the FSM leaves WAIT on it
  assign go_o  = en_i && (!inp_i || last);
  assign tmo_o = en_i && inp_i && last;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (!en_i || !inp_i) begin
      cnt_q <= '0;
    end else if (!last) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/panda_div_cfg.sv
// Register-side controller for panda_div: shadow DIVISOR/FIRST_PULSE registers
// committed atomically at a safe point, with FORCE, COUNT snapshot and STATUS.
module panda_div_cfg
  import panda_div_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_cs_i,
  input  logic        mem_wstb_i,
  input  logic        mem_rstb_i,
  input  logic [3:0]  mem_addr_i,
  input  logic [31:0] mem_dat_i,
  output logic [31:0] mem_dat_o,
  output logic        mem_rack_o,
  input  logic        inp_i,
  input  logic [31:0] COUNT_i,
  output logic [31:0] DIVISOR_o,
  output logic        FIRST_PULSE_o,
  output logic        FORCE_RST_o,
  output logic        busy_o
);

  state_e      state_q;
  logic [31:0] div_sh_q, div_stg_q;
  logic        fp_sh_q, fp_stg_q;
  logic        err_zero_q, err_ovr_q, tmo_q;

  logic        wr, rd, commit, force_wr, sts_clr;
  logic        go, tmo;
  logic [3:0]  sts;
  logic [31:0] rdata;

  assign busy_o = (state_q != StIdle);

  panda_div_safe #(
    .TIMEOUT(TIMEOUT)
  ) u_safe (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (state_q == StWait),
    .inp_i(inp_i),
    .go_o (go),
    .tmo_o(tmo)
  );

  always_comb begin
    wr       = mem_cs_i && mem_wstb_i;
    rd       = mem_cs_i && mem_rstb_i;
    commit   = wr && (mem_addr_i == AddrCommit);
    force_wr = wr && (mem_addr_i == AddrForce);
    sts_clr  = rd && (mem_addr_i == AddrStatus);

    sts             = '0;
    sts[BitBusy]    = busy_o;
    sts[BitErrZero] = err_zero_q;
    sts[BitErrOvr]  = err_ovr_q;
    sts[BitTmo]     = tmo_q;

    rdata = '0;
    case (mem_addr_i)
      AddrDivisor:    rdata = div_sh_q;
      AddrFirstPulse: rdata = {31'd0, fp_sh_q};
      AddrCount:      rdata = COUNT_i;
      AddrStatus:     rdata = {28'd0, sts};
      default:        rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= StIdle;
      div_sh_q      <= 32'd1;
      fp_sh_q       <= 1'b0;
      div_stg_q     <= '0;
      fp_stg_q      <= 1'b0;
      err_zero_q    <= 1'b0;
      err_ovr_q     <= 1'b0;
      tmo_q         <= 1'b0;
      DIVISOR_o     <= 32'd1;
      FIRST_PULSE_o <= 1'b0;
      FORCE_RST_o   <= 1'b0;
      mem_rack_o    <= 1'b0;
      mem_dat_o     <= '0;
    end else begin
      mem_rack_o <= rd;
      mem_dat_o  <= rd ? rdata : '0;

      if (wr && (mem_addr_i == AddrDivisor))    div_sh_q <= mem_dat_i;
      if (wr && (mem_addr_i == AddrFirstPulse)) fp_sh_q  <= mem_dat_i[0];

      // A set in the same cycle as a STATUS read survives the clear
      err_zero_q <= (commit && (state_q == StIdle) && (div_sh_q == '0)) ||
                    (err_zero_q && !sts_clr);
      err_ovr_q  <= (commit && (state_q != StIdle)) || (err_ovr_q && !sts_clr);
      tmo_q      <= tmo || (tmo_q && !sts_clr);

      // OR-ing both sources keeps a coinciding FORCE and APPLY to one pulse
      FORCE_RST_o <= force_wr || (state_q == StApply);

      case (state_q)
        StIdle: begin
          if (commit && (div_sh_q != '0)) begin
            div_stg_q <= div_sh_q;
            fp_stg_q  <= fp_sh_q;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (go) state_q <= StApply;
        end
        StApply: begin
          DIVISOR_o     <= div_stg_q;
          FIRST_PULSE_o <= fp_stg_q;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_div_cfg.sv
// Scoreboard bench for panda_div_cfg: a default-TIMEOUT instance and a TIMEOUT=4
// instance share the bus; expected reads and FORCE_RST pulses are queued per instance.
module tb_panda_div_cfg;

  typedef struct {
    int unsigned cyc;
    logic [31:0] div;
    logic        fp;
  } ap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs [2];
  logic        wstb, rstb, inp;
  logic [3:0]  addr;
  logic [31:0] wdat, count;

  logic [31:0] dat [2];
  logic        rack [2];
  logic [31:0] div_o [2];
  logic        fp_o [2];
  logic        frc [2];
  logic        busy [2];

  logic [31:0] rd_q [2][$];
  ap_t         ap_q [2][$];

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  panda_div_cfg dut0 (
    .clk_i(clk), .rst_i(rst), .mem_cs_i(cs[0]), .mem_wstb_i(wstb), .mem_rstb_i(rstb),
    .mem_addr_i(addr), .mem_dat_i(wdat), .mem_dat_o(dat[0]), .mem_rack_o(rack[0]),
    .inp_i(inp), .COUNT_i(count), .DIVISOR_o(div_o[0]), .FIRST_PULSE_o(fp_o[0]),
    .FORCE_RST_o(frc[0]), .busy_o(busy[0])
  );

  panda_div_cfg #(
    .TIMEOUT(4)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .mem_cs_i(cs[1]), .mem_wstb_i(wstb), .mem_rstb_i(rstb),
    .mem_addr_i(addr), .mem_dat_i(wdat), .mem_dat_o(dat[1]), .mem_rack_o(rack[1]),
    .inp_i(inp), .COUNT_i(count), .DIVISOR_o(div_o[1]), .FIRST_PULSE_o(fp_o[1]),
    .FORCE_RST_o(frc[1]), .busy_o(busy[1])
  );

  // Monitor: every rack and every FORCE_RST cycle must match the next queued entry
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rack[s]) begin
        n_vec++;
        if (rd_q[s].size() == 0) begin
          n_err++;
          $display("FAIL rack%0d unexpected: data=%0h expected no read", s, dat[s]);
        end else begin
          logic [31:0] e;
          e = rd_q[s].pop_front();
          if (dat[s] !== e) begin
            n_err++;
            $display("FAIL read%0d at cycle %0d: got %0h expected %0h", s, cyc, dat[s], e);
          end
        end
      end
      if (frc[s]) begin
        n_vec++;
        if (ap_q[s].size() == 0) begin
          n_err++;
          $display("FAIL force%0d unexpected pulse at cycle %0d", s, cyc);
        end else begin
          ap_t a;
          a = ap_q[s].pop_front();
          if (cyc != a.cyc || div_o[s] !== a.div || fp_o[s] !== a.fp) begin
            n_err++;
            $display("FAIL force%0d: got cyc=%0d div=%0d fp=%0b expected cyc=%0d div=%0d fp=%0b",
                     s, cyc, div_o[s], fp_o[s], a.cyc, a.div, a.fp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic op(input int sel, input bit w, input bit r, input logic [3:0] a,
                    input logic [31:0] d, input logic [31:0] exp_rd);
    cs[0] = (sel == 0);
    cs[1] = (sel == 1);
    wstb  = w;
    rstb  = r;
    addr  = a;
    wdat  = d;
    if (r) rd_q[sel].push_back(exp_rd);
    cycle(1);
    cs[0] = 1'b0;
    cs[1] = 1'b0;
    wstb  = 1'b0;
    rstb  = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d);
    op(sel, 1'b1, 1'b0, a, d, 32'd0);
  endtask

  task automatic rd(input int sel, input logic [3:0] a, input logic [31:0] e);
    op(sel, 1'b0, 1'b1, a, 32'd0, e);
  endtask

  task automatic push_ap(input int sel, input int unsigned c, input logic [31:0] d,
                         input logic f);
    ap_t a;
    a.cyc = c;
    a.div = d;
    a.fp  = f;
    ap_q[sel].push_back(a);
  endtask

  initial begin
    rst = 1'b0; inp = 1'b0; count = '0; wstb = 1'b0; rstb = 1'b0;
    addr = '0; wdat = '0; cs[0] = 1'b0; cs[1] = 1'b0;
    cycle(3);
    for (int s = 0; s < 2; s++) begin
      chk("rst_divisor", div_o[s], 32'd1);
      chk("rst_first_pulse", {31'd0, fp_o[s]}, 32'd0);
      chk("rst_force", {31'd0, frc[s]}, 32'd0);
      chk("rst_busy", {31'd0, busy[s]}, 32'd0);
      chk("rst_rack", {31'd0, rack[s]}, 32'd0);
      chk("rst_dat", dat[s], 32'd0);
    end
    rst = 1'b1;
    cycle(1);
    rd(0, 4'd0, 32'd1);
    rd(0, 4'd1, 32'd0);
    rd(0, 4'd5, 32'd0);

    // Basic commit
    wr(0, 4'd0, 32'd5);
    wr(0, 4'd1, 32'd1);
    rd(0, 4'd0, 32'd5);
    rd(0, 4'd1, 32'd1);
    n = cyc;
    wr(0, 4'd3, 32'd0);
    push_ap(0, n + 3, 32'd5, 1'b1);
    chk("busy_n1", {31'd0, busy[0]}, 32'd1);
    cycle(1);
    chk("busy_n2", {31'd0, busy[0]}, 32'd1);
    chk("div_before_apply", div_o[0], 32'd1);
    cycle(1);
    chk("busy_n3", {31'd0, busy[0]}, 32'd0);
    chk("div_applied", div_o[0], 32'd5);
    cycle(3);

    // Safe-point wait, no timeout
    inp = 1'b1;
    cycle(10);
    wr(0, 4'd0, 32'd7);
    n = cyc;
    wr(0, 4'd3, 32'd0);
    cycle(3);
    inp = 1'b0;
    push_ap(0, n + 6, 32'd7, 1'b1);
    cycle(4);
    rd(0, 4'd5, 32'd0);

    // Zero divisor rejected
    wr(0, 4'd0, 32'd0);
    wr(0, 4'd3, 32'd0);
    rd(0, 4'd5, 32'h2);
    rd(0, 4'd5, 32'h0);
    chk("zero_div_unchanged", div_o[0], 32'd7);
    cycle(3);

    // Overrun: second COMMIT during WAIT
    wr(0, 4'd0, 32'd3);
    inp = 1'b1;
    n = cyc;
    wr(0, 4'd3, 32'd0);
    wr(0, 4'd0, 32'd9);
    wr(0, 4'd3, 32'd0);
    inp = 1'b0;
    push_ap(0, n + 5, 32'd3, 1'b1);
    cycle(4);
    chk("ovr_div_kept", div_o[0], 32'd3);
    rd(0, 4'd5, 32'h4);
    rd(0, 4'd0, 32'd9);

    // FORCE landing on the APPLY cycle, then a lone FORCE
    n = cyc;
    wr(0, 4'd3, 32'd0);
    cycle(1);
    wr(0, 4'd2, 32'd0);
    push_ap(0, n + 3, 32'd9, 1'b1);
    cycle(3);
    n = cyc;
    wr(0, 4'd2, 32'd0);
    push_ap(0, n + 1, 32'd9, 1'b1);
    cycle(2);

    // COUNT snapshot, unmapped read, simultaneous write+read
    count = 32'd123;
    rd(0, 4'd4, 32'd123);
    rd(0, 4'd9, 32'd0);
    op(0, 1'b1, 1'b1, 4'd0, 32'd11, 32'd9);
    rd(0, 4'd0, 32'd11);
    cycle(2);

    // Reset during WAIT aborts the commit
    inp = 1'b1;
    wr(0, 4'd3, 32'd0);
    cycle(1);
    rst = 1'b0;
    cycle(1);
    chk("rstw_divisor", div_o[0], 32'd1);
    chk("rstw_first_pulse", {31'd0, fp_o[0]}, 32'd0);
    chk("rstw_busy", {31'd0, busy[0]}, 32'd0);
    rst = 1'b1;
    rd(0, 4'd0, 32'd1);
    rd(0, 4'd1, 32'd0);
    rd(0, 4'd5, 32'd0);
    inp = 1'b0;
    cycle(2);

    // Timeout with TIMEOUT=4
    wr(1, 4'd0, 32'd6);
    inp = 1'b1;
    n = cyc;
    wr(1, 4'd3, 32'd0);
    push_ap(1, n + 6, 32'd6, 1'b0);
    cycle(7);
    inp = 1'b0;
    rd(1, 4'd5, 32'h8);
    rd(1, 4'd5, 32'h0);
    chk("tmo_div_applied", div_o[1], 32'd6);

    cycle(5);
    for (int s = 0; s < 2; s++) begin
      chk("reads_drained", rd_q[s].size(), 32'd0);
      chk("forces_drained", ap_q[s].size(), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
